// File: rtl/idex_hazard_stage.sv
// idex_hazard_stage: ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional saturating bubble counter under `define IDEX_BUBBLE_CNT_EN.
module idex_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] RsAddr_i,
    input  logic [ADDR_W-1:0] RtAddr_i,
    input  logic [ADDR_W-1:0] RdAddr_i,
    input  logic [DATA_W-1:0] RsData_i,
    input  logic [DATA_W-1:0] RtData_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [1:0]        WB_i,
    input  logic [1:0]        M_i,
    input  logic [3:0]        EX_i,
    output logic [ADDR_W-1:0] RsAddr_o,
    output logic [ADDR_W-1:0] RtAddr_o,
    output logic [ADDR_W-1:0] RdAddr_o,
    output logic [DATA_W-1:0] RsData_o,
    output logic [DATA_W-1:0] RtData_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [1:0]        WB_o,
    output logic [1:0]        M_o,
    output logic [3:0]        EX_o,
    output logic              valid_o,
    output logic              hazard_stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);
    logic hazard;
    logic bubble;
    assign hazard = valid_o & M_o[1] & (RtAddr_o != '0) & ((RtAddr_o == RsAddr_i) | (RtAddr_o == RtAddr_i));
    assign bubble = hazard | flush_i;
    assign hazard_stall_o = hazard & ~flush_i;
    always_ff @(posedge clk_i) begin
        if (rst_i | (~stall_i & bubble)) begin
            RsAddr_o <= '0;
            RtAddr_o <= '0;
            RdAddr_o <= '0;
            RsData_o <= '0;
            RtData_o <= '0;
            Imm_o    <= '0;
            WB_o     <= '0;
            M_o      <= '0;
            EX_o     <= '0;
            valid_o  <= 1'b0;
        end else if (~stall_i) begin
            RsAddr_o <= RsAddr_i;
            RtAddr_o <= RtAddr_i;
            RdAddr_o <= RdAddr_i;
            RsData_o <= RsData_i;
            RtData_o <= RtData_i;
            Imm_o    <= Imm_i;
            WB_o     <= WB_i;
            M_o      <= M_i;
            EX_o     <= EX_i;
            valid_o  <= 1'b1;
        end
    end
`ifdef IDEX_BUBBLE_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            bubble_cnt_o <= '0;
        else if (~stall_i & bubble & (bubble_cnt_o != '1))
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
`else
    assign bubble_cnt_o = '0;
`endif
endmodule

// File: tb/tb_idex_hazard_stage.sv
// tb_idex_hazard_stage: randomized + directed scoreboard bench for idex_hazard_stage.
module tb_idex_hazard_stage;
    localparam int CW = 4;
    localparam int VW = 5 * 3 + 32 * 3 + 2 + 2 + 4 + 1 + CW;

    logic clk = 1'b0;
    logic rst = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [4:0] rs_a = '0, rt_a = '0, rd_a = '0;
    logic [31:0] rs_d = '0, rt_d = '0, imm = '0;
    logic [1:0] wb = '0, m = '0;
    logic [3:0] ex = '0;
    logic [4:0] rs_q, rt_q, rd_q;
    logic [31:0] rsd_q, rtd_q, imm_q;
    logic [1:0] wb_q, m_q;
    logic [3:0] ex_q;
    logic v_q, hs;
    logic [CW-1:0] cnt_q;

    idex_hazard_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .RsAddr_i(rs_a), .RtAddr_i(rt_a), .RdAddr_i(rd_a),
        .RsData_i(rs_d), .RtData_i(rt_d), .Imm_i(imm),
        .WB_i(wb), .M_i(m), .EX_i(ex),
        .RsAddr_o(rs_q), .RtAddr_o(rt_q), .RdAddr_o(rd_q),
        .RsData_o(rsd_q), .RtData_o(rtd_q), .Imm_o(imm_q),
        .WB_o(wb_q), .M_o(m_q), .EX_o(ex_q),
        .valid_o(v_q), .hazard_stall_o(hs), .bubble_cnt_o(cnt_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [1:0] wb, m;
        logic [3:0] ex;
        logic v;
        int bubbles;
    } ex_slot_t;

    ex_slot_t mdl;
    logic primed = 1'b0;
    logic [VW-1:0] q[$];
    int total = 0, bad = 0;
    int last_rs = 0;

    function automatic logic [VW-1:0] pack_model(ex_slot_t s);
        logic [CW-1:0] c;
`ifdef IDEX_BUBBLE_CNT_EN
        c = (s.bubbles > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(s.bubbles);
`else
        c = '0;
`endif
        return {s.rs, s.rt, s.rd, s.rsd, s.rtd, s.imm, s.wb, s.m, s.ex, s.v, c};
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic [VW-1:0] e, a;
            e = q.pop_front();
            a = {rs_q, rt_q, rd_q, rsd_q, rtd_q, imm_q, wb_q, m_q, ex_q, v_q, cnt_q};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL regs: got %h want %h (valid %b/%b cnt %0d/%0d)", a, e, a[CW], e[CW], a[CW-1:0], e[CW-1:0]);
            end
        end
    end

    task automatic cyc(input logic r, input logic s, input logic f, input logic [4:0] a_rs,
                       input logic [4:0] a_rt, input logic [4:0] a_rd, input logic [1:0] c_wb,
                       input logic [1:0] c_m, input logic [3:0] c_ex);
        logic load_in_ex, uses, exp_hs;
        @(negedge clk);
        #2;
        rst = r; stall = s; flush = f;
        rs_a = a_rs; rt_a = a_rt; rd_a = a_rd;
        rs_d = $urandom; rt_d = $urandom; imm = $urandom;
        wb = c_wb; m = c_m; ex = c_ex;
        #1;
        // A load in EX whose destination is read by the ID instruction forces one bubble.
        load_in_ex = mdl.v && mdl.m[1] && mdl.rt != 0;
        uses = (mdl.rt == a_rs) || (mdl.rt == a_rt);
        exp_hs = load_in_ex && uses && !f;
        if (primed) begin
            total++;
            if (hs !== exp_hs) begin
                bad++;
                $display("FAIL hazard_stall: got %b want %b (ex.rt=%0d rs=%0d rt=%0d flush=%b)", hs, exp_hs, mdl.rt, a_rs, a_rt, f);
            end
        end
        if (r) begin
            mdl = '{default: 0};
        end else if (!s) begin
            if ((load_in_ex && uses) || f) begin
                mdl = '{bubbles: mdl.bubbles + 1, default: 0};
            end else begin
                mdl = '{rs: a_rs, rt: a_rt, rd: a_rd, rsd: rs_d, rtd: rt_d, imm: imm,
                        wb: c_wb, m: c_m, ex: c_ex, v: 1'b1, bubbles: mdl.bubbles};
            end
        end
        if (r) primed = 1'b1;
        if (primed) q.push_back(pack_model(mdl));
    endtask

    initial begin
        mdl = '{default: 0};
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use: lw Rt=8 then add Rs=8 held for the bubble, then captured
        cyc(0, 0, 0, 5'd2, 5'd8, 5'd0, 2'b11, 2'b10, 4'b0001);
        cyc(0, 0, 0, 5'd8, 5'd9, 5'd10, 2'b10, 2'b00, 4'b1100);
        cyc(0, 0, 0, 5'd8, 5'd9, 5'd10, 2'b10, 2'b00, 4'b1100);
        // Rt=0 load never stalls
        cyc(0, 0, 0, 5'd3, 5'd0, 5'd0, 2'b11, 2'b10, 4'b0001);
        cyc(0, 0, 0, 5'd0, 5'd4, 5'd5, 2'b10, 2'b00, 4'b1100);
        // flush with and without a coincident hazard
        cyc(0, 0, 1, 5'd1, 5'd2, 5'd3, 2'b10, 2'b00, 4'b1100);
        cyc(0, 0, 0, 5'd3, 5'd7, 5'd0, 2'b11, 2'b10, 4'b0001);
        cyc(0, 0, 1, 5'd7, 5'd1, 5'd2, 2'b10, 2'b00, 4'b1100);
        cyc(0, 0, 0, 5'd7, 5'd1, 5'd2, 2'b10, 2'b00, 4'b1100);
        // external stall for 3 cycles, including over a hazard
        cyc(0, 0, 0, 5'd3, 5'd6, 5'd0, 2'b11, 2'b10, 4'b0001);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 5'(6 + i), 5'(i), 5'(i), 2'(i), 2'(i), 4'(i));
        cyc(0, 0, 0, 5'd11, 5'd12, 5'd13, 2'b10, 2'b01, 4'b1010);
        // reset during a hazard cycle
        cyc(0, 0, 0, 5'd3, 5'd9, 5'd0, 2'b11, 2'b10, 4'b0001);
        cyc(1, 0, 0, 5'd9, 5'd1, 5'd2, 2'b10, 2'b00, 4'b1100);
        cyc(0, 0, 0, 5'd9, 5'd9, 5'd2, 2'b10, 2'b00, 4'b1100);
        // 20 flushes saturate a 4-bit counter, then reset clears it
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 5'(i), 5'(i), 5'(i), 2'b11, 2'b10, 4'hf);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            int k;
            k = $urandom_range(0, 99);
            cyc(k == 0, k >= 1 && k < 12, k >= 12 && k < 20,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                2'($urandom), ($urandom_range(0, 2) == 0) ? 2'b10 : 2'($urandom_range(0, 1)), 4'($urandom));
        end
        @(negedge clk);
        #4;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
